// File: rtl/mod_chain.sv
// rtl/mod_chain.sv - cascaded up/down modulo-MOD digit counter with look-ahead carry/borrow
// Digit i steps only when every lower digit sits at its terminal value (MOD-1 up, 0 down).
module mod_chain #(
   parameter int MOD    = 10,
   parameter int DIGITS = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            cen,
   input  logic                            up,
   input  logic                            clr,
   input  logic                            load,
   input  logic [DIGITS*$clog2(MOD)-1:0]   load_val,
   output logic [DIGITS*$clog2(MOD)-1:0]   q,
   output logic                            sync_ovf,
   output logic                            wrap,
   output logic                            is_zero
);

   localparam int               WIDTH = $clog2(MOD);
   localparam logic [WIDTH-1:0] MAX_D = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] ONE_D = WIDTH'(1);
   localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);

   logic [WIDTH-1:0]  digit_q [DIGITS];
   logic [WIDTH-1:0]  digit_d [DIGITS];
   logic [WIDTH-1:0]  field;
   logic [DIGITS-1:0] step_up;
   logic [DIGITS-1:0] step_dn;
   logic              all_max;
   logic              all_zero;
   logic              wrap_q;

   // Enables come from current register values only, so all digits move on one edge.
   always_comb begin
      all_max  = 1'b1;
      all_zero = 1'b1;
      step_up  = '0;
      step_dn  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         step_up[i] = all_max;
         step_dn[i] = all_zero;
         all_max    = all_max  & (digit_q[i] == MAX_D);
         all_zero   = all_zero & (digit_q[i] == '0);
      end
   end

   assign sync_ovf = cen & ~clr & ~load & (up ? all_max : all_zero);
   assign is_zero  = all_zero;
   assign wrap     = wrap_q;

   always_comb begin
      field = '0;
      for (int i = 0; i < DIGITS; i++) begin
         digit_d[i] = digit_q[i];
         if (clr) begin
            digit_d[i] = '0;
         end else if (load) begin
            // Out-of-range load fields clamp so no digit ever holds a value >= MOD.
            field      = load_val[i*WIDTH +: WIDTH];
            digit_d[i] = ({1'b0, field} >= MOD_W) ? MAX_D : field;
         end else if (cen) begin
            if (up && step_up[i]) begin
               digit_d[i] = (digit_q[i] == MAX_D) ? '0 : digit_q[i] + ONE_D;
            end else if (!up && step_dn[i]) begin
               digit_d[i] = (digit_q[i] == '0) ? MAX_D : digit_q[i] - ONE_D;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DIGITS; i++) digit_q[i] <= '0;
         wrap_q <= 1'b0;
      end else begin
         for (int i = 0; i < DIGITS; i++) digit_q[i] <= digit_d[i];
         wrap_q <= sync_ovf;
      end
   end

   always_comb begin
      q = '0;
      for (int i = 0; i < DIGITS; i++) q[i*WIDTH +: WIDTH] = digit_q[i];
   end

endmodule

// File: tb/tb_mod_chain.sv
// tb/tb_mod_chain.sv - directed self-checking bench for mod_chain
module tb_mod_chain;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // Main instance: MOD=10, DIGITS=4
   logic        cen, up, clr, load;
   logic [15:0] load_val, q;
   logic        sync_ovf, wrap, is_zero;

   mod_chain #(.MOD(10), .DIGITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .q(q), .sync_ovf(sync_ovf), .wrap(wrap), .is_zero(is_zero));

   // Two chained MOD=6 single digits
   logic       c_cen, c_clr;
   logic [2:0] c0_q, c1_q;
   logic       c0_ovf, c1_ovf, c0_wrap, c1_wrap, c0_zero, c1_zero;

   mod_chain #(.MOD(6), .DIGITS(1)) ch0 (
      .clk(clk), .rst_n(rst_n), .cen(c_cen), .up(1'b1), .clr(c_clr), .load(1'b0),
      .load_val(3'd0), .q(c0_q), .sync_ovf(c0_ovf), .wrap(c0_wrap), .is_zero(c0_zero));

   mod_chain #(.MOD(6), .DIGITS(1)) ch1 (
      .clk(clk), .rst_n(rst_n), .cen(c0_ovf), .up(1'b1), .clr(c_clr), .load(1'b0),
      .load_val(3'd0), .q(c1_q), .sync_ovf(c1_ovf), .wrap(c1_wrap), .is_zero(c1_zero));

   // Single binary digit instance
   logic p_cen, p_clr, p_q, p_ovf, p_wrap, p_zero;

   mod_chain #(.MOD(2), .DIGITS(1)) p2 (
      .clk(clk), .rst_n(rst_n), .cen(p_cen), .up(1'b1), .clr(p_clr), .load(1'b0),
      .load_val(1'b0), .q(p_q), .sync_ovf(p_ovf), .wrap(p_wrap), .is_zero(p_zero));

   // Two hex digits behave as an 8-bit binary counter
   logic       b_cen, b_up, b_clr;
   logic [7:0] b_q;
   logic       b_ovf, b_wrap, b_zero;

   mod_chain #(.MOD(16), .DIGITS(2)) b16 (
      .clk(clk), .rst_n(rst_n), .cen(b_cen), .up(b_up), .clr(b_clr), .load(1'b0),
      .load_val(8'd0), .q(b_q), .sync_ovf(b_ovf), .wrap(b_wrap), .is_zero(b_zero));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] bref;
      int         wraps;

      rst_n = 1'b0; cen = 0; up = 1; clr = 0; load = 0; load_val = '0;
      c_cen = 0; c_clr = 0; p_cen = 0; p_clr = 0; b_cen = 0; b_up = 1; b_clr = 0;
      tick; tick;
      chk("reset_q", q, 16'h0000);
      chk("reset_wrap", wrap, 1'b0);
      chk("reset_is_zero", is_zero, 1'b1);
      chk("reset_sync_ovf", sync_ovf, 1'b0);

      // Asynchronous reset mid-count
      rst_n = 1'b1;
      load = 1; load_val = 16'h0357;
      tick;
      load = 0;
      chk("load_0357", q, 16'h0357);
      chk("is_zero_low", is_zero, 1'b0);
      cen = 1; up = 1;
      tick;
      chk("count_0358", q, 16'h0358);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_q", q, 16'h0000);
      chk("async_rst_wrap", wrap, 1'b0);
      chk("async_rst_zero", is_zero, 1'b1);
      cen = 0;
      tick;
      rst_n = 1'b1;

      // Up wrap through 9999
      load = 1; load_val = 16'h9998; cen = 1; up = 1;
      tick;
      chk("load_beats_cen", q, 16'h9998);
      load = 0;
      #1 chk("ovf_9998", sync_ovf, 1'b0);
      tick;
      chk("up_9999", q, 16'h9999);
      chk("ovf_9999", sync_ovf, 1'b1);
      chk("wrap_9999", wrap, 1'b0);
      tick;
      chk("up_0000", q, 16'h0000);
      chk("wrap_pulse", wrap, 1'b1);
      chk("zero_after_wrap", is_zero, 1'b1);
      tick;
      chk("up_0001", q, 16'h0001);
      chk("wrap_clear", wrap, 1'b0);

      // Down borrow
      load = 1; load_val = 16'h1000;
      tick;
      load = 0; up = 0;
      tick;
      chk("down_0999", q, 16'h0999);
      tick;
      chk("down_0998", q, 16'h0998);
      load = 1; load_val = 16'h0000;
      tick;
      load = 0;
      #1 chk("ovf_down_0000", sync_ovf, 1'b1);
      chk("wrap_after_load", wrap, 1'b0);
      tick;
      chk("down_9999", q, 16'h9999);
      chk("down_wrap", wrap, 1'b1);

      // Priority and clamping
      load = 1; load_val = 16'h0042;
      tick;
      clr = 1; load = 1; cen = 1;
      #1 chk("ovf_blocked_by_clr", sync_ovf, 1'b0);
      tick;
      chk("clr_priority", q, 16'h0000);
      chk("clr_wrap", wrap, 1'b0);
      clr = 0; load = 1; load_val = 16'h0C07;
      tick;
      chk("clamp_0907", q, 16'h0907);
      load_val = 16'hFA5B;
      tick;
      chk("clamp_9959", q, 16'h9959);
      load_val = 16'h0907;
      tick;
      load = 0; up = 1;
      tick;
      chk("up_0908", q, 16'h0908);
      up = 0;
      tick;
      chk("dir_change_0907", q, 16'h0907);
      cen = 0;
      tick;
      chk("hold_0907", q, 16'h0907);

      // Chained MOD=6 pair: 36 enabled cycles return both to 0, upper wraps once
      c_clr = 1;
      tick;
      c_clr = 0; c_cen = 1;
      wraps = 0;
      for (int k = 1; k <= 36; k++) begin
         tick;
         chk("chain_lo", c0_q, 32'(k % 6));
         chk("chain_hi", c1_q, 32'((k / 6) % 6));
         if (c1_wrap) wraps++;
      end
      c_cen = 0;
      chk("chain_hi_wraps", wraps, 1);
      chk("chain_lo_end", c0_q, 3'd0);
      chk("chain_hi_end", c1_q, 3'd0);

      // Single binary digit
      p_clr = 1;
      tick;
      p_clr = 0; p_cen = 1;
      #1;
      chk("mod2_q0", p_q, 1'b0);
      chk("mod2_ovf0", p_ovf, 1'b0);
      tick;
      chk("mod2_q1", p_q, 1'b1);
      chk("mod2_ovf1", p_ovf, 1'b1);
      tick;
      chk("mod2_q0b", p_q, 1'b0);
      chk("mod2_wrap", p_wrap, 1'b1);
      p_cen = 0;

      // Two hex digits against an 8-bit binary model with random direction
      b_clr = 1;
      tick;
      b_clr = 0; b_cen = 1;
      bref = 8'd0;
      for (int k = 0; k < 300; k++) begin
         b_up = 1'($urandom_range(0, 1));
         #1 chk("bin_ovf", b_ovf, b_up ? (bref == 8'hFF) : (bref == 8'h00));
         tick;
         bref = b_up ? bref + 8'd1 : bref - 8'd1;
         chk("bin_q", b_q, bref);
      end
      b_cen = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
